// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V control path.
// Holds the control FSM state encoding, ALU operation codes, base opcodes and
// the mux select encodings driven by the controller.
package riscv_pkg;

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecuteR = 4'd6,
      StExecuteI = 4'd7,
      StAluWb    = 4'd8,
      StBranch   = 4'd9,
      StJal      = 4'd10,
      StJalr     = 4'd11,
      StJalrWb   = 4'd12,
      StLui      = 4'd13,
      StAuipc    = 4'd14,
      StTrap     = 4'd15
   } state_e;

   // ALU operations
   localparam logic [3:0] AluAdd  = 4'b0000;
   localparam logic [3:0] AluSub  = 4'b0001;
   localparam logic [3:0] AluAnd  = 4'b0010;
   localparam logic [3:0] AluOr   = 4'b0011;
   localparam logic [3:0] AluXor  = 4'b0100;
   localparam logic [3:0] AluSlt  = 4'b0101;
   localparam logic [3:0] AluSltu = 4'b0110;
   localparam logic [3:0] AluSll  = 4'b0111;
   localparam logic [3:0] AluSrl  = 4'b1000;
   localparam logic [3:0] AluSra  = 4'b1001;

   // Base opcodes
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpI      = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;

   // Result mux
   localparam logic [1:0] RsAluOut    = 2'b00;
   localparam logic [1:0] RsData      = 2'b01;
   localparam logic [1:0] RsAluResult = 2'b10;

   // SrcA mux
   localparam logic [1:0] SaPc    = 2'b00;
   localparam logic [1:0] SaOldPc = 2'b01;
   localparam logic [1:0] SaRd1   = 2'b10;
   localparam logic [1:0] SaZero  = 2'b11;

   // SrcB mux
   localparam logic [1:0] SbWriteData = 2'b00;
   localparam logic [1:0] SbImm       = 2'b01;
   localparam logic [1:0] SbFour      = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decoder.
// Ports:
//   funct3_i    - instruction funct3 field
//   funct7b5_i  - instruction bit 30
//   is_rtype_i  - 1 for register-register ops (selects SUB for funct3=000)
//   alu_ctrl_o  - ALU operation code
module alu_decoder
   import riscv_pkg::*;
(
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   input  logic       is_rtype_i,
   output logic [3:0] alu_ctrl_o
);

   always_comb begin
      alu_ctrl_o = AluAdd;
      unique case (funct3_i)
         // addi has no subtract form; bit 30 there is immediate data
         3'b000:  alu_ctrl_o = (is_rtype_i && funct7b5_i) ? AluSub : AluAdd;
         3'b001:  alu_ctrl_o = AluSll;
         3'b010:  alu_ctrl_o = AluSlt;
         3'b011:  alu_ctrl_o = AluSltu;
         3'b100:  alu_ctrl_o = AluXor;
         3'b101:  alu_ctrl_o = funct7b5_i ? AluSra : AluSrl;
         3'b110:  alu_ctrl_o = AluOr;
         3'b111:  alu_ctrl_o = AluAnd;
         default: alu_ctrl_o = AluAdd;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V controller: Moore FSM sequencing fetch, decode and the
// per-class execute/writeback steps. BRANCH's pc_write also depends on the
// current ALU flags.
// Ports:
//   clk, reset (async, active-low)   Instr: IR contents
//   zero/negative/carryout/overflow  ALU flags of this cycle's result
//   pc_write, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
//   ALUSrca, ALUSrcb, RegWrite       datapath controls
//   illegal: high in TRAP            state: current state (debug)
module mc_control_fsm
   import riscv_pkg::*;
#(
   parameter int unsigned TRAP_ON_ILLEGAL = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr,
   input  logic        zero,
   input  logic        negative,
   input  logic        carryout,
   input  logic        overflow,
   output logic        pc_write,
   output logic        AdrSrc,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic [1:0]  ResultSrc,
   output logic [3:0]  ALUControl,
   output logic [1:0]  ALUSrca,
   output logic [1:0]  ALUSrcb,
   output logic        RegWrite,
   output logic        illegal,
   output logic [3:0]  state
);

   state_e     state_q, state_d;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [3:0] alu_dec;
   logic       taken;
   logic       pc_write_s, mem_write_s, ir_write_s, reg_write_s;

   assign opcode = Instr[6:0];
   assign funct3 = Instr[14:12];

   alu_decoder u_alu_decoder (
      .funct3_i   (funct3),
      .funct7b5_i (Instr[30]),
      .is_rtype_i (opcode == OpR),
      .alu_ctrl_o (alu_dec)
   );

   // carryout=1 means the subtraction did not borrow (unsigned a >= b)
   always_comb begin
      taken = 1'b0;
      unique case (funct3)
         3'b000:  taken = zero;
         3'b001:  taken = ~zero;
         3'b100:  taken = negative ^ overflow;
         3'b101:  taken = ~(negative ^ overflow);
         3'b110:  taken = ~carryout;
         3'b111:  taken = carryout;
         default: taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_write_s  = 1'b0;
      mem_write_s = 1'b0;
      ir_write_s  = 1'b0;
      reg_write_s = 1'b0;
      AdrSrc      = 1'b0;
      ResultSrc   = RsAluOut;
      ALUControl  = AluAdd;
      ALUSrca     = SaPc;
      ALUSrcb     = SbWriteData;
      unique case (state_q)
         StFetch: begin
            ALUSrcb    = SbFour;
            ResultSrc  = RsAluResult;
            ir_write_s = 1'b1;
            pc_write_s = 1'b1;
            state_d    = StDecode;
         end
         StDecode: begin
            ALUSrca = SaOldPc;
            ALUSrcb = SbImm;
            unique case (opcode)
               OpLoad, OpStore: state_d = StMemAdr;
               OpR:             state_d = StExecuteR;
               OpI:             state_d = StExecuteI;
               OpBranch:        state_d = StBranch;
               OpJal:           state_d = StJal;
               OpJalr:          state_d = StJalr;
               OpLui:           state_d = StLui;
               OpAuipc:         state_d = StAuipc;
               default:         state_d = (TRAP_ON_ILLEGAL != 0) ? StTrap : StFetch;
            endcase
         end
         StMemAdr: begin
            ALUSrca = SaRd1;
            ALUSrcb = SbImm;
            state_d = (opcode == OpLoad) ? StMemRead : StMemWrite;
         end
         StMemRead: begin
            AdrSrc  = 1'b1;
            state_d = StMemWb;
         end
         StMemWb: begin
            ResultSrc   = RsData;
            reg_write_s = 1'b1;
            state_d     = StFetch;
         end
         StMemWrite: begin
            AdrSrc      = 1'b1;
            mem_write_s = 1'b1;
            state_d     = StFetch;
         end
         StExecuteR: begin
            ALUSrca    = SaRd1;
            ALUControl = alu_dec;
            state_d    = StAluWb;
         end
         StExecuteI: begin
            ALUSrca    = SaRd1;
            ALUSrcb    = SbImm;
            ALUControl = alu_dec;
            state_d    = StAluWb;
         end
         StAluWb: begin
            reg_write_s = 1'b1;
            state_d     = StFetch;
         end
         StBranch: begin
            ALUSrca    = SaRd1;
            ALUControl = AluSub;
            pc_write_s = taken;
            state_d    = StFetch;
         end
         StJal: begin
            ALUSrca    = SaOldPc;
            ALUSrcb    = SbFour;
            pc_write_s = 1'b1;
            state_d    = StAluWb;
         end
         StJalr: begin
            ALUSrca    = SaRd1;
            ALUSrcb    = SbImm;
            ResultSrc  = RsAluResult;
            pc_write_s = 1'b1;
            state_d    = StJalrWb;
         end
         StJalrWb: begin
            ALUSrca     = SaOldPc;
            ALUSrcb     = SbFour;
            ResultSrc   = RsAluResult;
            reg_write_s = 1'b1;
            state_d     = StFetch;
         end
         StLui: begin
            ALUSrca = SaZero;
            ALUSrcb = SbImm;
            state_d = StAluWb;
         end
         StAuipc: begin
            ALUSrca = SaOldPc;
            ALUSrcb = SbImm;
            state_d = StAluWb;
         end
         StTrap: begin
            state_d = StTrap;
         end
         default: state_d = StFetch;
      endcase
   end

   // State already reads FETCH during reset, but FETCH's enables must not
   // reach the datapath until reset is released.
   assign pc_write = pc_write_s & reset;
   assign MemWrite = mem_write_s & reset;
   assign IRWrite  = ir_write_s & reset;
   assign RegWrite = reg_write_s & reset;
   assign illegal  = (state_q == StTrap);
   assign state    = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: a trapping and a non-trapping instance
// share stimulus; per-cycle expected outputs are queued at issue and checked
// on the falling edge.
module tb_mc_control_fsm;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Instr;
   logic        zero, negative, carryout, overflow;

   logic a_pw, a_adr, a_mw, a_irw, a_rw, a_ill;
   logic [1:0] a_rs, a_sa, a_sb;
   logic [3:0] a_alu, a_st;
   logic b_pw, b_adr, b_mw, b_irw, b_rw, b_ill;
   logic [1:0] b_rs, b_sa, b_sb;
   logic [3:0] b_alu, b_st;

   mc_control_fsm #(.TRAP_ON_ILLEGAL(1)) dut (
      .clk(clk), .reset(reset), .Instr(Instr), .zero(zero), .negative(negative),
      .carryout(carryout), .overflow(overflow), .pc_write(a_pw), .AdrSrc(a_adr),
      .MemWrite(a_mw), .IRWrite(a_irw), .ResultSrc(a_rs), .ALUControl(a_alu),
      .ALUSrca(a_sa), .ALUSrcb(a_sb), .RegWrite(a_rw), .illegal(a_ill), .state(a_st)
   );

   mc_control_fsm #(.TRAP_ON_ILLEGAL(0)) dut0 (
      .clk(clk), .reset(reset), .Instr(Instr), .zero(zero), .negative(negative),
      .carryout(carryout), .overflow(overflow), .pc_write(b_pw), .AdrSrc(b_adr),
      .MemWrite(b_mw), .IRWrite(b_irw), .ResultSrc(b_rs), .ALUControl(b_alu),
      .ALUSrca(b_sa), .ALUSrcb(b_sb), .RegWrite(b_rw), .illegal(b_ill), .state(b_st)
   );

   always #5 clk = ~clk;

   logic [19:0] obs1, obs0;
   assign obs1 = {a_st, a_pw, a_adr, a_mw, a_irw, a_rs, a_alu, a_sa, a_sb, a_rw, a_ill};
   assign obs0 = {b_st, b_pw, b_adr, b_mw, b_irw, b_rs, b_alu, b_sa, b_sb, b_rw, b_ill};

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [19:0] e1;
      logic [19:0] e0;
      string       tag;
   } exp_t;
   exp_t sbq[$];
   logic [19:0] mq[$];

   // Monitor: every falling edge with pending expectations is one output step
   exp_t mx;
   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         mx = sbq.pop_front();
         checks += 2;
         if (obs1 !== mx.e1) begin
            errors++;
            $display("FAIL %s trap-dut: got %h want %h", mx.tag, obs1, mx.e1);
         end
         if (obs0 !== mx.e0) begin
            errors++;
            $display("FAIL %s nop-dut: got %h want %h", mx.tag, obs0, mx.e0);
         end
      end
   end

   function automatic void check(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endfunction

   // Expected output vector for one cycle
   function automatic logic [19:0] o(state_e st, logic pw, logic adr, logic mw, logic irw,
                                     logic [1:0] rs, logic [3:0] alu, logic [1:0] sa,
                                     logic [1:0] sb, logic rw);
      logic [3:0] s;
      s = st;
      return {s, pw, adr, mw, irw, rs, alu, sa, sb, rw, st == StTrap};
   endfunction

   // ALU op from the funct3/funct7 table
   function automatic logic [3:0] exp_alu(logic [31:0] ins);
      logic [2:0] f3;
      logic       b5, r;
      f3 = ins[14:12];
      b5 = ins[30];
      r  = (ins[6:0] == 7'b0110011);
      case (f3)
         3'd0:    return (r && b5) ? 4'b0001 : 4'b0000;
         3'd1:    return 4'b0111;
         3'd2:    return 4'b0101;
         3'd3:    return 4'b0110;
         3'd4:    return 4'b0100;
         3'd5:    return b5 ? 4'b1001 : 4'b1000;
         3'd6:    return 4'b0011;
         default: return 4'b0010;
      endcase
   endfunction

   // Fill mq with the per-cycle expectations of one instruction
   function automatic void model(logic [31:0] ins, logic taken, bit trap);
      logic [3:0] a;
      a = exp_alu(ins);
      mq.push_back(o(StFetch, 1, 0, 0, 1, 2'b10, 4'b0000, 2'b00, 2'b10, 0));
      mq.push_back(o(StDecode, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b01, 2'b01, 0));
      case (ins[6:0])
         7'b0000011: begin
            mq.push_back(o(StMemAdr, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b10, 2'b01, 0));
            mq.push_back(o(StMemRead, 0, 1, 0, 0, 2'b00, 4'b0000, 2'b00, 2'b00, 0));
            mq.push_back(o(StMemWb, 0, 0, 0, 0, 2'b01, 4'b0000, 2'b00, 2'b00, 1));
         end
         7'b0100011: begin
            mq.push_back(o(StMemAdr, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b10, 2'b01, 0));
            mq.push_back(o(StMemWrite, 0, 1, 1, 0, 2'b00, 4'b0000, 2'b00, 2'b00, 0));
         end
         7'b0110011: begin
            mq.push_back(o(StExecuteR, 0, 0, 0, 0, 2'b00, a, 2'b10, 2'b00, 0));
            mq.push_back(o(StAluWb, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 2'b00, 1));
         end
         7'b0010011: begin
            mq.push_back(o(StExecuteI, 0, 0, 0, 0, 2'b00, a, 2'b10, 2'b01, 0));
            mq.push_back(o(StAluWb, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 2'b00, 1));
         end
         7'b1100011:
            mq.push_back(o(StBranch, taken, 0, 0, 0, 2'b00, 4'b0001, 2'b10, 2'b00, 0));
         7'b1101111: begin
            mq.push_back(o(StJal, 1, 0, 0, 0, 2'b00, 4'b0000, 2'b01, 2'b10, 0));
            mq.push_back(o(StAluWb, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 2'b00, 1));
         end
         7'b1100111: begin
            mq.push_back(o(StJalr, 1, 0, 0, 0, 2'b10, 4'b0000, 2'b10, 2'b01, 0));
            mq.push_back(o(StJalrWb, 0, 0, 0, 0, 2'b10, 4'b0000, 2'b01, 2'b10, 1));
         end
         7'b0110111: begin
            mq.push_back(o(StLui, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b11, 2'b01, 0));
            mq.push_back(o(StAluWb, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 2'b00, 1));
         end
         7'b0010111: begin
            mq.push_back(o(StAuipc, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b01, 2'b01, 0));
            mq.push_back(o(StAluWb, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 2'b00, 1));
         end
         default: begin
            if (trap) begin
               for (int i = 0; i < 10; i++)
                  mq.push_back(o(StTrap, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 2'b00, 0));
            end
         end
      endcase
   endfunction

   // Issue one instruction with branch operands a,b; ncut>0 truncates the
   // expectation to the first ncut cycles. Called just after a rising edge.
   task automatic issue(string tag, logic [31:0] ins, logic [31:0] a, logic [31:0] b,
                        int ncut);
      logic [32:0] d;
      logic        tk;
      logic [19:0] q1[$];
      logic [19:0] q0[$];
      exp_t        e;
      int          n;
      d = {1'b0, a} + {1'b0, ~b} + 33'd1;
      case (ins[14:12])
         3'd0:    tk = (a == b);
         3'd1:    tk = (a != b);
         3'd4:    tk = ($signed(a) < $signed(b));
         3'd5:    tk = ($signed(a) >= $signed(b));
         3'd6:    tk = (a < b);
         3'd7:    tk = (a >= b);
         default: tk = 1'b0;
      endcase
      mq.delete();
      model(ins, tk, 1'b1);
      q1 = mq;
      mq.delete();
      // The non-trapping instance keeps re-running the held instruction
      while (mq.size() < q1.size()) model(ins, tk, 1'b0);
      q0 = mq;
      n = (ncut > 0) ? ncut : q1.size();
      for (int i = 0; i < n; i++) begin
         e.e1  = q1[i];
         e.e0  = q0[i];
         e.tag = $sformatf("%s[%0d]", tag, i);
         sbq.push_back(e);
      end
      Instr    = ins;
      zero     = (d[31:0] == 32'd0);
      negative = d[31];
      carryout = d[32];
      overflow = (a[31] != b[31]) && (d[31] != a[31]);
      for (int i = 0; i < 40 && sbq.size() > 0; i++) begin
         @(posedge clk);
         #1;
      end
      if (sbq.size() > 0) begin
         errors++;
         $display("FAIL %s timeout: got %0d pending want 0", tag, sbq.size());
         sbq.delete();
      end
   endtask

   logic [6:0] ops[9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                          7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

   initial begin
      logic [31:0] ins, a, b;
      reset = 1'b0;
      Instr = 32'h0;
      {zero, negative, carryout, overflow} = 4'b0;
      #2;
      check("rst_state", {28'd0, a_st}, {28'd0, 4'(StFetch)});
      check("rst_illegal", {31'd0, a_ill}, 32'd0);
      check("rst_enables", {28'd0, a_pw, a_irw, a_rw, a_mw}, 32'd0);
      check("rst_enables0", {28'd0, b_pw, b_irw, b_rw, b_mw}, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      issue("addi", 32'h00500093, 0, 0, 0);
      issue("lw", 32'h0000A103, 0, 0, 0);
      issue("beq_t", 32'h00208463, 32'h1234, 32'h1234, 0);
      issue("beq_n", 32'h00208463, 32'h1234, 32'h1235, 0);
      issue("sub", 32'h40208033, 0, 0, 0);
      issue("srai", 32'h4010D093, 0, 0, 0);

      for (int k = 0; k < 60; k++) begin
         ins      = $urandom;
         ins[6:0] = ops[$urandom_range(0, 8)];
         a        = $urandom;
         case ($urandom_range(0, 3))
            0:       b = a;
            1:       b = a ^ 32'h8000_0000;
            default: b = $urandom;
         endcase
         issue($sformatf("rnd%0d", k), ins, a, b, 0);
      end

      // Illegal opcode: TRAP for 10 cycles vs. NOP re-fetching
      issue("illegal", 32'hFFFFFFFF, 0, 0, 0);
      reset = 1'b0;
      #1;
      check("trap_rst_state", {28'd0, a_st}, {28'd0, 4'(StFetch)});
      check("trap_rst_illegal", {31'd0, a_ill}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;

      // Reset during MEMWRITE
      issue("sw_cut", 32'h0020A023, 0, 0, 3);
      check("sw_memwrite_hi", {31'd0, a_mw}, 32'd1);
      reset = 1'b0;
      #1;
      check("sw_memwrite_rst", {31'd0, a_mw}, 32'd0);
      check("sw_state_rst", {28'd0, a_st}, {28'd0, 4'(StFetch)});
      @(posedge clk);
      #1;
      check("sw_state_held", {28'd0, a_st}, {28'd0, 4'(StFetch)});
      reset = 1'b1;
      issue("addi_after", 32'h00500093, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
